// File: rtl/fifo_rd_stream_if.sv
// Downstream ready/valid stream carrying words read out of an SRAM-backed FIFO.
// The master modport belongs to the reader front-end and the slave modport to the consumer.
interface fifo_rd_stream_if #(
    parameter int WIDTH = 16
);
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// Reader front-end for fixed-latency SRAM FIFOs. Pops are issued against credits, and returned
// words land in a small skid buffer that drains as a bubble-free ready/valid stream.
module fifo_rd_stream #(
    parameter int WIDTH = 16,
    parameter int LAT   = 2,
    parameter int BUF   = LAT + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 fifo_empty,
    output logic                 fifo_pop,
    output logic                 fifo_flush,
    input  logic                 fifo_valid,
    input  logic [WIDTH-1:0]     fifo_rdata,
    fifo_rd_stream_if.master     m,
    output logic [$clog2(BUF):0] buf_cnt,
    output logic                 err
);
    localparam int CW = $clog2(BUF) + 1;
    localparam int PW = (BUF > 1) ? $clog2(BUF) : 1;
    localparam int DW = $clog2(LAT + 1);
    localparam logic [CW:0]   BUF_SUM     = (CW + 1)'(BUF);
    localparam logic [CW-1:0] BUF_CNT     = CW'(BUF);
    localparam logic [PW-1:0] LAST        = PW'(BUF - 1);
    localparam logic [DW-1:0] DROP_RELOAD = DW'(LAT - 1);

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    infl;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [DW-1:0]    drop;
    logic [WIDTH-1:0] mem [BUF];

    logic        ret;
    logic        capture;
    logic        transfer;
    logic        overflow;
    logic        stray;
    logic        retire;
    logic [CW:0] committed;

    // Pop depends only on registered credit state, fifo_empty and flush, never on m_ready.
    always_comb begin
        committed = {1'b0, cnt} + {1'b0, infl};
        ret       = fifo_valid && (drop == '0) && !flush;
        transfer  = m.m_valid && m.m_ready;
        overflow  = ret && (cnt == BUF_CNT) && !transfer;
        capture   = ret && !overflow;
        stray     = ret && (infl == '0);
        retire    = ret && (infl != '0);
        fifo_pop  = !flush && (drop == '0) && !fifo_empty && (committed < BUF_SUM);
    end

    assign fifo_flush = flush;
    assign m.m_valid  = (cnt != '0);
    assign m.m_data   = m.m_valid ? mem[head] : '0;
    assign buf_cnt    = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            infl <= '0;
            head <= '0;
            tail <= '0;
            drop <= '0;
            err  <= 1'b0;
        end else if (flush) begin
            // Reads already issued still return; drop masks them for LAT-1 more cycles.
            cnt  <= '0;
            infl <= '0;
            head <= '0;
            tail <= '0;
            drop <= DROP_RELOAD;
        end else begin
            case ({fifo_pop, retire})
                2'b10:   infl <= infl + 1'b1;
                2'b01:   infl <= infl - 1'b1;
                default: infl <= infl;
            endcase
            case ({capture, transfer})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (capture) begin
                tail <= (tail == LAST) ? '0 : tail + 1'b1;
            end
            if (transfer) begin
                head <= (head == LAST) ? '0 : head + 1'b1;
            end
            if (drop != '0) begin
                drop <= drop - 1'b1;
            end
            if (stray || overflow) begin
                err <= 1'b1;
            end
        end
    end

    // Skid buffer storage carries no reset; occupancy is tracked by cnt alone.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[tail] <= fifo_rdata;
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural LAT=2 FIFO on the read side.
module tb_fifo_rd_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        fifo_flush;
    logic        fifo_valid;
    logic [15:0] fifo_rdata;
    logic [2:0]  buf_cnt;
    logic        err;

    logic        inj = 1'b0;
    logic [15:0] inj_data = 16'h0;

    int total = 0;
    int bad = 0;

    fifo_rd_stream_if #(.WIDTH(16)) s_if ();

    fifo_rd_stream #(.WIDTH(16), .LAT(2), .BUF(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .fifo_flush (fifo_flush),
        .fifo_valid (fifo_valid),
        .fifo_rdata (fifo_rdata),
        .m          (s_if),
        .buf_cnt    (buf_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: two-cycle read pipeline, flush/reset discard stored words only.
    logic [15:0] fmem [1024];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          pop_cnt = 0;
    logic        pv0 = 1'b0;
    logic        pv1 = 1'b0;
    logic [15:0] pd0 = 16'h0;
    logic [15:0] pd1 = 16'h0;

    always @(posedge clk) begin
        if (rst || fifo_flush) rd_ptr <= wr_ptr;
        else if (fifo_pop) rd_ptr <= rd_ptr + 1;
        if (fifo_pop) pop_cnt <= pop_cnt + 1;
        pv0 <= fifo_pop && !rst;
        pv1 <= pv0 && !rst;
        pd0 <= fmem[rd_ptr % 1024];
        pd1 <= pd0;
    end

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_valid = pv1 | inj;
    assign fifo_rdata = inj ? inj_data : pd1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        fmem[wr_ptr % 1024] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accepts n words with m_ready held high and checks them against base, base+1, ...
    task automatic recv(input int n, input logic [15:0] base, input string tag);
        int got = 0;
        s_if.m_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && got < n; cyc++) begin
            #1;
            if (s_if.m_valid === 1'b1) begin
                check(tag, 32'(s_if.m_data), 32'(base) + 32'(got));
                got = got + 1;
            end
            tick();
        end
        check({tag, "_count"}, 32'(got), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap;
        int pushed;
        int got;
        s_if.m_ready = 1'b0;

        // Reset
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_pop", 32'(fifo_pop), 32'd0);
        check("rst_mvalid", 32'(s_if.m_valid), 32'd0);
        check("rst_mdata", 32'(s_if.m_data), 32'd0);
        check("rst_bufcnt", 32'(buf_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Streaming: three-cycle pop-to-valid latency, then 32 words back to back
        tick();
        s_if.m_ready = 1'b1;
        for (int i = 1; i <= 32; i++) push(16'(i));
        #1;
        check("stream_first_pop", 32'(fifo_pop), 32'd1);
        check("stream_lat0", 32'(s_if.m_valid), 32'd0);
        tick();
        check("stream_lat1", 32'(s_if.m_valid), 32'd0);
        tick();
        check("stream_lat2", 32'(s_if.m_valid), 32'd0);
        tick();
        for (int k = 1; k <= 32; k++) begin
            check("stream_valid", 32'(s_if.m_valid), 32'd1);
            check("stream_data", 32'(s_if.m_data), 32'(k));
            tick();
        end
        check("stream_drained", 32'(s_if.m_valid), 32'd0);
        check("stream_err", 32'(err), 32'd0);

        // Backpressure: credits cap outstanding work at four words
        repeat (2) tick();
        s_if.m_ready = 1'b0;
        snap = pop_cnt;
        for (int i = 1; i <= 8; i++) push(16'(i));
        repeat (8) tick();
        #1;
        check("bp_pop_stopped", 32'(fifo_pop), 32'd0);
        check("bp_pops", 32'(pop_cnt - snap), 32'd4);
        check("bp_bufcnt", 32'(buf_cnt), 32'd4);
        check("bp_head", 32'(s_if.m_data), 32'h0001);
        check("bp_err", 32'(err), 32'd0);
        recv(8, 16'h0001, "bp_data");
        check("bp_empty", 32'(buf_cnt), 32'd0);

        // Random ready and random FIFO fill gaps
        pushed = 0;
        got = 0;
        for (int cyc = 0; cyc < 4000 && got < 200; cyc++) begin
            if (pushed < 200 && $urandom_range(0, 2) != 0) begin
                push(16'(16'h1000 + pushed));
                pushed = pushed + 1;
            end
            s_if.m_ready = 1'($urandom_range(0, 1));
            #1;
            if (s_if.m_valid === 1'b1 && s_if.m_ready === 1'b1) begin
                check("rnd_data", 32'(s_if.m_data), 32'(16'h1000 + got));
                got = got + 1;
            end
            tick();
        end
        check("rnd_count", 32'(got), 32'd200);
        check("rnd_err", 32'(err), 32'd0);

        // Flush with two reads in flight and buffered words
        s_if.m_ready = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 6; i++) push(16'(16'h0050 + i));
        #1;
        check("fl_first_pop", 32'(fifo_pop), 32'd1);
        repeat (4) tick();
        check("fl_pre_bufcnt", 32'(buf_cnt), 32'd2);
        flush = 1'b1;
        #1;
        check("fl_fifo_flush", 32'(fifo_flush), 32'd1);
        check("fl_pop_t", 32'(fifo_pop), 32'd0);
        check("fl_mvalid_t", 32'(s_if.m_valid), 32'd1);
        tick();
        flush = 1'b0;
        #1;
        check("fl_mvalid_t1", 32'(s_if.m_valid), 32'd0);
        check("fl_bufcnt_t1", 32'(buf_cnt), 32'd0);
        push(16'hBEEF);
        #1;
        check("fl_pop_drop", 32'(fifo_pop), 32'd0);
        tick();
        check("fl_pop_resume", 32'(fifo_pop), 32'd1);
        recv(1, 16'hBEEF, "fl_beef");
        check("fl_after", 32'(s_if.m_valid), 32'd0);
        check("fl_err", 32'(err), 32'd0);

        // Stray fifo_valid with nothing in flight
        repeat (3) tick();
        s_if.m_ready = 1'b1;
        inj_data = 16'h1234;
        inj = 1'b1;
        #1;
        check("stray_err_before", 32'(err), 32'd0);
        tick();
        inj = 1'b0;
        #1;
        check("stray_err_set", 32'(err), 32'd1);
        repeat (3) tick();
        check("stray_err_hold", 32'(err), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (2) tick();
        check("stray_err_flush", 32'(err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("stray_err_rst", 32'(err), 32'd0);
        check("stray_bufcnt_rst", 32'(buf_cnt), 32'd0);
        check("stray_mvalid_rst", 32'(s_if.m_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
